// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and {l,g,e} result codes.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result vector ordering is {l, g, e}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/comp_digit.sv
// Combinational DIGIT-bit unsigned comparator for one operand slice.
// Zero latency; no flow control.
module comp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/comp_serial.sv
// Serial magnitude comparator, DIGIT bits per cycle from the MSB, with early exit on first difference.
// Latency 1..NDIG cycles from capture to done; start is ignored while busy.
module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         res_q, res_d;
  logic               done_q, done_d;
  logic               cap;
  logic [WIDTH-1:0]   msb_flip;
  logic [DIGIT-1:0]   a_sl, b_sl;
  logic               sl_lt, sl_gt, sl_eq;

  // Biasing the sign bit maps two's-complement order onto unsigned order
  assign msb_flip = {sgn, {(WIDTH-1){1'b0}}};

  assign a_sl = a_q[idx_q*DIGIT +: DIGIT];
  assign b_sl = b_q[idx_q*DIGIT +: DIGIT];

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sl),
    .b  (b_sl),
    .lt (sl_lt),
    .gt (sl_gt),
    .eq (sl_eq)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = IDX_W'(NDIG - 1);
          res_d   = RES_NONE;
          cap     = 1'b1;
        end
      end
      RUN: begin
        if (sl_lt) begin
          state_d = IDLE;
          res_d   = RES_LT;
          done_d  = 1'b1;
        end else if (sl_gt) begin
          state_d = IDLE;
          res_d   = RES_GT;
          done_d  = 1'b1;
        end else if (sl_eq && (idx_q == '0)) begin
          state_d = IDLE;
          res_d   = RES_EQ;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      done_q  <= done_d;
      if (cap) begin
        a_q <= A ^ msb_flip;
        b_q <= B ^ msb_flip;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign l    = res_q[2];
  assign g    = res_q[1];
  assign e    = res_q[0];

endmodule

// File: tb/tb_comp_serial.sv
// Randomized and directed scoreboard bench for comp_serial (WIDTH=8, DIGIT=2).
module tb_comp_serial;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] A, B;
  logic         busy, done, l, g, e;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  logic last_vld = 1'b0;
  logic [2:0] last_res = 3'b000;

  comp_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .g     (g),
    .e     (e)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge = rst;
  end

  // Reference: plain signed/unsigned compare; latency from the highest differing bit
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s, output int k);
    logic [W-1:0] diff;
    int hi;
    diff = a ^ b;
    hi = -1;
    for (int i = 0; i < W; i++) if (diff[i]) hi = i;
    k = (hi < 0) ? N : (N - hi / D);
    if (s) begin
      if ($signed(a) < $signed(b)) return 3'b100;
      if ($signed(a) > $signed(b)) return 3'b010;
    end else begin
      if (a < b) return 3'b100;
      if (a > b) return 3'b010;
    end
    return 3'b001;
  endfunction

  // Monitor: pops an expectation on every done pulse, checks hold between results
  always @(negedge clk) begin
    exp_t x;
    if (rst_at_edge) last_vld = 1'b0;
    if (done) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cyc=%0d lge=%b", cyc, {l, g, e});
      end else begin
        x = q.pop_front();
        if ({l, g, e} !== x.res || cyc != x.cyc || busy !== 1'b0) begin
          n_err++;
          $display("FAIL result lge=%b cyc=%0d busy=%b, required lge=%b cyc=%0d busy=0",
                   {l, g, e}, cyc, busy, x.res, x.cyc);
        end
        last_res = x.res;
        last_vld = 1'b1;
      end
    end else if (!busy && last_vld) begin
      n_cmp++;
      if ({l, g, e} !== last_res) begin
        n_err++;
        $display("FAIL hold lge=%b, required %b", {l, g, e}, last_res);
      end
    end
  end

  // Called at a negedge; returns one negedge later with junk on the operand inputs
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t x;
    int k;
    A = a; B = b; sgn = s; start = 1'b1;
    if (!busy && !rst) begin
      x.res = model(a, b, s, k);
      x.cyc = cyc + 1 + k;
      q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    sgn = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout busy=%b, required 0", busy);
    end
  endtask

  task automatic check_cleared(input string name);
    n_cmp++;
    if ({busy, done, l, g, e} !== 5'b0) begin
      n_err++;
      $display("FAIL %s busy/done/lge=%b, required 00000", name, {busy, done, l, g, e});
    end
  endtask

  initial begin
    exp_t dummy;
    int bc;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset_state");
    rst = 1'b0;

    issue(8'h12, 8'h13, 1'b0); wait_idle();
    issue(8'hC0, 8'h10, 1'b0); wait_idle();
    issue(8'hC0, 8'h10, 1'b1); wait_idle();
    issue(8'hFF, 8'hFE, 1'b1); wait_idle();

    issue(8'h55, 8'h55, 1'b0);
    bc = 1;
    while (busy && bc < 20) begin
      @(negedge clk);
      if (busy) bc++;
    end
    n_cmp++;
    if (bc != 4) begin
      n_err++;
      $display("FAIL busy_len got %0d cycles, required 4", bc);
    end
    wait_idle();

    // Start during busy is dropped; start on the done cycle is taken
    issue(8'h12, 8'h13, 1'b0);
    issue(8'h00, 8'hFF, 1'b0);
    wait_idle();
    issue(8'h03, 8'h03, 1'b1);
    wait_idle();
    issue(8'h80, 8'h7F, 1'b1);
    wait_idle();

    // Reset in the second RUN cycle aborts without done
    issue(8'h12, 8'h13, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dummy = q.pop_back();
    @(negedge clk);
    rst = 1'b0;
    check_cleared("rst_abort");
    repeat (6) @(negedge clk);

    // Reset beats a simultaneous start
    rst = 1'b1; start = 1'b1; A = 8'h01; B = 8'h02; sgn = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_cleared("rst_priority");
    repeat (2) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, 1'($urandom));
    end

    begin
      int t = 0;
      while (q.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain %0d results outstanding, required 0", q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
